frame_streamer: RTL
===================

FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 SHALL have parameter FRAME_H_MAX, default 224, meaning maximum frame height in pixels.
REQ-002 SHALL have parameter FRAME_W_MAX, default 224, meaning maximum frame width in pixels.
REQ-003 SHALL have parameter DIN_WIDTH, default 8, meaning bits per channel sample.
REQ-004 SHALL have parameter CH_NUM, default 4, meaning channels per pixel.
REQ-005 SHALL have parameter GAP_MAX, default 15, meaning maximum idle cycles between rows.
REQ-006 SHALL have port clk, input, 1 bit: single clock, all logic rising-edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have ports frame_h and frame_w, input, clog2(FRAME_H_MAX)+1 and clog2(FRAME_W_MAX)+1 bits: frame geometry, sampled at start.
REQ-009 SHALL have port line_gap, input, clog2(GAP_MAX)+1 bits: idle cycles inserted after each row except the last, sampled at start.
REQ-010 SHALL have port start, input, 1 bit: single-cycle request to stream one frame.
REQ-011 SHALL have ports busy and done, output, 1 bit each: busy high from accepted start until done; done is a 1-cycle completion pulse.
REQ-012 SHALL have ports rd_en (output, 1), rd_addr (output, clog2(FRAME_H_MAX*FRAME_W_MAX) bits) and rd_data (input, CH_NUM*DIN_WIDTH bits): frame memory with fixed 1-cycle read latency.
REQ-013 SHALL have ports frame_start (output, 1), dout_vld (output, 1) and dout (output, [CH_NUM-1:0][DIN_WIDTH-1:0]): pixel stream matching the convolution input of conv3d.

Function
REQ-014 SHALL implement FSM states IDLE, STREAM, GAP, FLUSH.
REQ-015 IDLE -> STREAM on start: latch frame_h, frame_w and line_gap; set row, col and address to 0; assert busy.
REQ-016 In STREAM, SHALL assert rd_en every cycle with row-major rd_addr = row*frame_w+col, generated incrementally without a multiplier.
REQ-017 STREAM -> GAP after the last column of a non-last row when latched line_gap > 0; GAP holds rd_en low for exactly line_gap cycles, then returns to STREAM.
REQ-018 STREAM -> FLUSH after the read of the last pixel; FLUSH lasts 2 cycles, then done pulses for one cycle and the FSM enters IDLE with busy low in the same cycle.
REQ-019 dout_vld SHALL assert exactly 2 cycles after the corresponding rd_en, with dout = the registered rd_data.
REQ-020 frame_start SHALL pulse for one cycle, coincident with dout_vld of pixel (0,0) only.
REQ-021 Every frame SHALL produce exactly frame_h*frame_w dout_vld cycles, with no gaps inside a row.
REQ-022 start while busy SHALL be ignored; geometry changes while busy SHALL have no effect.
REQ-023 frame_h = 0 or frame_w = 0 at start: no rd_en and no dout_vld; done pulses the next cycle; busy high for that one cycle.
REQ-024 frame_h > FRAME_H_MAX, frame_w > FRAME_W_MAX and line_gap > GAP_MAX SHALL each be clamped to their maximum when latched.
REQ-025 start in the same cycle as done SHALL be ignored; a new start is accepted from the following cycle.

Reset
REQ-026 reset SHALL return the FSM to IDLE and drive busy, done, rd_en, frame_start and dout_vld to 0, and rd_addr and dout to 0.
REQ-027 reset mid-frame SHALL abort immediately with no done pulse; pipeline stages SHALL be cleared so no stale dout_vld appears after reset deasserts.

Structure
REQ-028 clog2 SHALL come from functions_pkg; the state enum (streamer_state_t) SHALL live in a shared conv_pkg for reuse by the future output collector.
REQ-029 Row, column and address counters SHALL be one sub-module, frame_addr_gen, with inputs advance and clear and outputs row, col, addr, last_col and last_pix.

Verification
REQ-030 frame_h=3, frame_w=4, line_gap=0, memory word k = k -> 12 consecutive dout_vld, dout 0..11, frame_start with dout 0, done 2 cycles after the last rd_en.
REQ-031 frame_h=3, frame_w=4, line_gap=2 -> 3 bursts of 4 dout_vld separated by exactly 2 idle cycles; 16 cycles from first to last dout_vld.
REQ-032 frame_h=0, frame_w=5 -> no rd_en, done 1 cycle after start; frame_h=1, frame_w=1 -> single dout_vld with frame_start.
REQ-033 start repeated every cycle during a 2x2 frame, and again in the done cycle -> exactly one frame (4 pixels); next frame only after a later start.
REQ-034 reset asserted on the 5th pixel of a 4x4 frame -> all outputs 0 the next cycle, no done, no dout_vld afterwards; a subsequent start streams a full 16-pixel frame.
REQ-035 frame_w=FRAME_W_MAX+10, frame_h=2 -> 2*FRAME_W_MAX pixels streamed; final rd_addr = 2*FRAME_W_MAX-1.

Source files
------------

// File: rtl/conv_pkg.sv
// Types shared by the conv3d input streamer and its companion output collector.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      GAP    = 2'd2,
      FLUSH  = 2'd3
   } streamer_state_t;

endpackage

// File: rtl/functions_pkg.sv
// Shared elaboration-time helpers for sizing ports and counters.
package functions_pkg;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned result;
      result = 0;
      v = (value > 0) ? value - 1 : 0;
      while (v != 0) begin
         v = v >> 1;
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/frame_streamer_if.sv
// Frame-memory read port plus the pixel stream handed to the convolution input.
interface frame_streamer_if #(
   parameter int unsigned FRAME_H_MAX = 224,
   parameter int unsigned FRAME_W_MAX = 224,
   parameter int unsigned DIN_WIDTH   = 8,
   parameter int unsigned CH_NUM      = 4
);
   import functions_pkg::*;

   localparam int unsigned AW = clog2(FRAME_H_MAX * FRAME_W_MAX);

   logic                                rd_en;
   logic [AW-1:0]                       rd_addr;
   logic [CH_NUM*DIN_WIDTH-1:0]         rd_data;
   logic                                frame_start;
   logic                                dout_vld;
   logic [CH_NUM-1:0][DIN_WIDTH-1:0]    dout;

   modport master (
      output rd_en, rd_addr, frame_start, dout_vld, dout,
      input  rd_data
   );

   modport slave (
      input  rd_en, rd_addr, frame_start, dout_vld, dout,
      output rd_data
   );

endinterface

// File: rtl/frame_addr_gen.sv
// Row-major row/column/address counters for one frame; the address is stepped, never multiplied.
module frame_addr_gen #(
   parameter int unsigned H_W = 9,
   parameter int unsigned W_W = 9,
   parameter int unsigned A_W = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           advance,
   input  logic           clear,
   input  logic [H_W-1:0] frame_h,
   input  logic [W_W-1:0] frame_w,
   output logic [H_W-1:0] row,
   output logic [W_W-1:0] col,
   output logic [A_W-1:0] addr,
   output logic           last_col,
   output logic           last_pix
);

   assign last_col = ((col + W_W'(1)) == frame_w);
   assign last_pix = last_col && ((row + H_W'(1)) == frame_h);

   // Counters freeze on the final pixel so rd_addr keeps showing the last address read.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         row  <= '0;
         col  <= '0;
         addr <= '0;
      end else if (advance && !last_pix) begin
         addr <= addr + A_W'(1);
         if (last_col) begin
            col <= '0;
            row <= row + H_W'(1);
         end else begin
            col <= col + W_W'(1);
         end
      end
   end

endmodule

// File: rtl/frame_streamer.sv
// Reads one frame row-major from a 1-cycle-latency memory and emits it as a pixel stream
// with optional idle gaps between rows.
module frame_streamer
   import functions_pkg::*, conv_pkg::*;
#(
   parameter int unsigned FRAME_H_MAX = 224,
   parameter int unsigned FRAME_W_MAX = 224,
   parameter int unsigned DIN_WIDTH   = 8,
   parameter int unsigned CH_NUM      = 4,
   parameter int unsigned GAP_MAX     = 15
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [clog2(FRAME_H_MAX):0] frame_h,
   input  logic [clog2(FRAME_W_MAX):0] frame_w,
   input  logic [clog2(GAP_MAX):0]     line_gap,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   frame_streamer_if.master            bus
);

   localparam int unsigned HW = clog2(FRAME_H_MAX) + 1;
   localparam int unsigned WW = clog2(FRAME_W_MAX) + 1;
   localparam int unsigned GW = clog2(GAP_MAX) + 1;
   localparam int unsigned AW = clog2(FRAME_H_MAX * FRAME_W_MAX);

   streamer_state_t state, state_n;

   logic [HW-1:0] h_lat;
   logic [WW-1:0] w_lat;
   logic [GW-1:0] gap_lat;
   logic [GW-1:0] gap_cnt, gap_cnt_n;
   logic          flush_cnt, flush_n;
   logic          load;
   logic          rd_en_c;

   logic [HW-1:0] row;
   logic [WW-1:0] col;
   logic [AW-1:0] addr;
   logic          last_col;
   logic          last_pix;

   logic          vld_d1;
   logic          first_d1;
   logic [CH_NUM-1:0][DIN_WIDTH-1:0] rd_pix;

   frame_addr_gen #(
      .H_W (HW),
      .W_W (WW),
      .A_W (AW)
   ) u_addr_gen (
      .clk      (clk),
      .reset    (reset),
      .advance  (rd_en_c),
      .clear    (load),
      .frame_h  (h_lat),
      .frame_w  (w_lat),
      .row      (row),
      .col      (col),
      .addr     (addr),
      .last_col (last_col),
      .last_pix (last_pix)
   );

   assign bus.rd_en   = rd_en_c;
   assign bus.rd_addr = addr;
   assign rd_pix      = bus.rd_data;

   always_comb begin
      state_n   = state;
      gap_cnt_n = gap_cnt;
      flush_n   = flush_cnt;
      load      = 1'b0;
      rd_en_c   = 1'b0;
      done      = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) begin
               load = 1'b1;
               // Empty frame skips straight to the last flush cycle so done follows next cycle.
               if ((frame_h == '0) || (frame_w == '0)) begin
                  state_n = FLUSH;
                  flush_n = 1'b1;
               end else begin
                  state_n = STREAM;
               end
            end
         end
         STREAM: begin
            rd_en_c = 1'b1;
            if (last_pix) begin
               state_n = FLUSH;
               flush_n = 1'b0;
            end else if (last_col && (gap_lat != '0)) begin
               state_n   = GAP;
               gap_cnt_n = gap_lat - GW'(1);
            end
         end
         GAP: begin
            if (gap_cnt == '0) begin
               state_n = STREAM;
            end else begin
               gap_cnt_n = gap_cnt - GW'(1);
            end
         end
         FLUSH: begin
            if (flush_cnt) begin
               done    = 1'b1;
               state_n = IDLE;
            end else begin
               flush_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         h_lat           <= '0;
         w_lat           <= '0;
         gap_lat         <= '0;
         gap_cnt         <= '0;
         flush_cnt       <= 1'b0;
         vld_d1          <= 1'b0;
         first_d1        <= 1'b0;
         bus.dout_vld    <= 1'b0;
         bus.frame_start <= 1'b0;
         bus.dout        <= '0;
      end else begin
         state     <= state_n;
         gap_cnt   <= gap_cnt_n;
         flush_cnt <= flush_n;
         if (load) begin
            h_lat   <= (frame_h > HW'(FRAME_H_MAX)) ? HW'(FRAME_H_MAX) : frame_h;
            w_lat   <= (frame_w > WW'(FRAME_W_MAX)) ? WW'(FRAME_W_MAX) : frame_w;
            gap_lat <= (line_gap > GW'(GAP_MAX)) ? GW'(GAP_MAX) : line_gap;
         end
         // Stage 1 tracks the memory latency, stage 2 registers the returned word.
         vld_d1          <= rd_en_c;
         first_d1        <= rd_en_c && (row == '0) && (col == '0);
         bus.dout_vld    <= vld_d1;
         bus.frame_start <= first_d1;
         if (vld_d1) begin
            bus.dout <= rd_pix;
         end
      end
   end

endmodule
